// File: rtl/d_register_universal.sv
// d_register_universal
//   WIDTH-bit register with synchronous reset/set, load-enable and four modes:
//   parallel load, shift left, shift right and (optionally) rotate left.
//   A saturating shift counter and a done flag let a parent block use it as a
//   parallel-to-serial converter without external counting.
//
//   Optional feature macro: D_REGISTER_UNIVERSAL_ROTATE_EN
//     defined   : mode 11 rotates left and counts as a shift
//     undefined : mode 11 is a full hold (Q, serial_out, shift_count unchanged)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset (highest priority)
//   set          synchronous active-high set to all ones (below reset)
//   en           operation enable; low holds all state
//   mode         00 load, 01 shift left, 10 shift right, 11 rotate left
//   data         parallel load value
//   serial_in    fill bit for the vacated end in shift modes
//   Q / Q_bar    register contents and its complement
//   serial_out   registered bit most recently shifted/rotated out
//   shift_count  shifts since last load/set/reset, saturates at WIDTH
//   shift_done   high while shift_count == WIDTH
module d_register_universal #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         set,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [WIDTH-1:0]             data,
  input  logic                         serial_in,
  output logic [WIDTH-1:0]             Q,
  output logic [WIDTH-1:0]             Q_bar,
  output logic                         serial_out,
  output logic [$clog2(WIDTH+1)-1:0]   shift_count,
  output logic                         shift_done
);

  localparam int            CW      = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    M_LOAD = 2'b00,
    M_SHL  = 2'b01,
    M_SHR  = 2'b10,
    M_ROL  = 2'b11
  } mode_e;

  // Counter value after one more shift; holds once the word is exhausted.
  logic [CW-1:0] cnt_next;
  assign cnt_next = (shift_count == CNT_MAX) ? shift_count : shift_count + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      Q           <= RESET_VALUE;
      serial_out  <= 1'b0;
      shift_count <= '0;
    end else if (set) begin
      Q           <= {WIDTH{1'b1}};
      serial_out  <= 1'b0;
      shift_count <= '0;
    end else if (en) begin
      case (mode_e'(mode))
        M_LOAD: begin
          // serial_out deliberately keeps the last shifted bit
          Q           <= data;
          shift_count <= '0;
        end
        M_SHL: begin
          serial_out  <= Q[WIDTH-1];
          Q           <= {Q[WIDTH-2:0], serial_in};
          shift_count <= cnt_next;
        end
        M_SHR: begin
          serial_out  <= Q[0];
          Q           <= {serial_in, Q[WIDTH-1:1]};
          shift_count <= cnt_next;
        end
        M_ROL: begin
`ifdef D_REGISTER_UNIVERSAL_ROTATE_EN
          serial_out  <= Q[WIDTH-1];
          Q           <= {Q[WIDTH-2:0], Q[WIDTH-1]};
          shift_count <= cnt_next;
`else
          // rotate disabled: mode 11 is a hold
          Q           <= Q;
`endif
        end
        default: Q <= Q;
      endcase
    end
  end

  // Derived straight from the registers so they can never disagree with them.
  assign Q_bar      = ~Q;
  assign shift_done = (shift_count == CNT_MAX);

endmodule

// File: tb/tb_d_register_universal.sv
// Bench for d_register_universal (WIDTH=8): a directed cycle table covering
// reset, load/hold, serialization, shift-right fill, set priority, rotate and
// reset mid-shift, followed by random stimulus against an arithmetic model.
module tb_d_register_universal;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, set, en, serial_in;
  logic [1:0]   mode;
  logic [W-1:0] data;
  logic [W-1:0] Q, Q_bar;
  logic         serial_out;
  logic [3:0]   shift_count;
  logic         shift_done;

  int pass_cnt = 0;
  int total    = 0;

  d_register_universal #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .set(set), .en(en), .mode(mode), .data(data),
    .serial_in(serial_in), .Q(Q), .Q_bar(Q_bar), .serial_out(serial_out),
    .shift_count(shift_count), .shift_done(shift_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, st, en;
    logic [1:0] mode;
    logic [7:0] data;
    logic       sin;
    logic [7:0] eq;
    logic       eso;
    logic [3:0] ecnt;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic e, logic [1:0] m,
                              logic [7:0] d, logic si, logic [7:0] q,
                              logic so, logic [3:0] c);
    vec_t v;
    v.rst = r; v.st = s; v.en = e; v.mode = m; v.data = d; v.sin = si;
    v.eq = q; v.eso = so; v.ecnt = c;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic drive(logic r, logic s, logic e, logic [1:0] m,
                       logic [7:0] d, logic si);
    reset = r; set = s; en = e; mode = m; data = d; serial_in = si;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, int idx, int q, int so, int c);
    chk({tag, ".Q"},     idx, 32'(Q),           32'(q));
    chk({tag, ".Q_bar"}, idx, 32'(Q_bar),       32'(~q & 'hFF));
    chk({tag, ".so"},    idx, 32'(serial_out),  32'(so));
    chk({tag, ".cnt"},   idx, 32'(shift_count), 32'(c));
    chk({tag, ".done"},  idx, 32'(shift_done),  32'(c == W));
  endtask

  vec_t tbl[29];

  // Arithmetic reference state
  int mq, mso, mcnt;

  initial begin
    reset = 1'b0; set = 1'b0; en = 1'b0; mode = 2'b00; data = '0; serial_in = 1'b0;

    //              rst set en mode  data  sin   Q    so cnt
    tbl[0]  = mk(1, 1, 1, 2'b01, 8'h5A, 1, 8'h00, 0, 0); // reset beats set/en
    tbl[1]  = mk(0, 0, 1, 2'b00, 8'hA5, 0, 8'hA5, 0, 0); // load
    tbl[2]  = mk(0, 0, 0, 2'b00, 8'h33, 0, 8'hA5, 0, 0); // hold x3
    tbl[3]  = mk(0, 0, 0, 2'b01, 8'h33, 1, 8'hA5, 0, 0);
    tbl[4]  = mk(0, 0, 0, 2'b10, 8'h33, 1, 8'hA5, 0, 0);
    tbl[5]  = mk(0, 0, 1, 2'b00, 8'hA5, 0, 8'hA5, 0, 0); // reload
    tbl[6]  = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'h4A, 1, 1); // serialize A5
    tbl[7]  = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'h94, 0, 2);
    tbl[8]  = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'h28, 1, 3);
    tbl[9]  = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'h50, 0, 4);
    tbl[10] = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'hA0, 0, 5);
    tbl[11] = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'h40, 1, 6);
    tbl[12] = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'h80, 0, 7);
    tbl[13] = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'h00, 1, 8); // done
    tbl[14] = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'h00, 0, 8); // saturated
    tbl[15] = mk(0, 0, 1, 2'b00, 8'h00, 1, 8'h00, 0, 0); // load 00
    tbl[16] = mk(0, 0, 1, 2'b10, 8'hFF, 1, 8'h80, 0, 1); // right fill
    tbl[17] = mk(0, 0, 1, 2'b10, 8'hFF, 1, 8'hC0, 0, 2);
    tbl[18] = mk(0, 0, 1, 2'b10, 8'hFF, 1, 8'hE0, 0, 3);
    tbl[19] = mk(0, 0, 1, 2'b10, 8'hFF, 1, 8'hF0, 0, 4);
    tbl[20] = mk(0, 1, 1, 2'b01, 8'h12, 0, 8'hFF, 0, 0); // set beats shift
    tbl[21] = mk(0, 0, 1, 2'b00, 8'h81, 0, 8'h81, 0, 0);
`ifdef D_REGISTER_UNIVERSAL_ROTATE_EN
    tbl[22] = mk(0, 0, 1, 2'b11, 8'h00, 0, 8'h03, 1, 1); // rotate
`else
    tbl[22] = mk(0, 0, 1, 2'b11, 8'h00, 1, 8'h81, 0, 0); // mode 11 holds
`endif
    tbl[23] = mk(0, 0, 1, 2'b00, 8'h3C, 0, 8'h3C, 0, 0);
    tbl[24] = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'h78, 0, 1);
    tbl[25] = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'hF0, 0, 2);
    tbl[26] = mk(0, 0, 1, 2'b01, 8'h00, 0, 8'hE0, 1, 3);
    tbl[27] = mk(1, 0, 1, 2'b01, 8'h00, 0, 8'h00, 0, 0); // reset on 4th shift
    tbl[28] = mk(0, 0, 1, 2'b01, 8'h00, 1, 8'h01, 0, 1); // restart from 00

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].en, tbl[i].mode, tbl[i].data, tbl[i].sin);
      chk_all("tbl", i, int'(tbl[i].eq), int'(tbl[i].eso), int'(tbl[i].ecnt));
    end

    // Hand sequence: mixing directions keeps counting, and saturation holds
    // while Q keeps moving.
    drive(0, 0, 1, 2'b00, 8'hC3, 0);
    for (int k = 0; k < 10; k++)
      drive(0, 0, 1, (k % 2 == 0) ? 2'b01 : 2'b10, 8'h00, 1'(k % 3 == 0));
    chk("mix.cnt",  0, 32'(shift_count), 32'd8);
    chk("mix.done", 0, 32'(shift_done),  32'd1);
    // en low with mode 11 holds regardless of the macro
    drive(0, 0, 0, 2'b11, 8'h00, 0);
    chk("mix.hold", 0, 32'(shift_count), 32'd8);

    // Random phase; first cycle resets so the model starts in sync.
    mq = 0; mso = 0; mcnt = 0;
    for (int n = 0; n < 400; n++) begin
      logic       r, s, e, si;
      logic [1:0] m;
      logic [7:0] d;
      r  = (n == 0) || ($urandom_range(0, 29) == 0);
      s  = ($urandom_range(0, 24) == 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      si = 1'($urandom);
      drive(r, s, e, m, d, si);
      if (r) begin
        mq = 0; mso = 0; mcnt = 0;
      end else if (s) begin
        mq = 255; mso = 0; mcnt = 0;
      end else if (e) begin
        case (m)
          2'd0: begin mq = int'(d); mcnt = 0; end
          2'd1: begin mso = mq / 128; mq = (mq * 2) % 256 + int'(si);
                      if (mcnt < W) mcnt++; end
          2'd2: begin mso = mq % 2; mq = mq / 2 + 128 * int'(si);
                      if (mcnt < W) mcnt++; end
          default: begin
`ifdef D_REGISTER_UNIVERSAL_ROTATE_EN
            mso = mq / 128; mq = (mq * 2) % 256 + mq / 128;
            if (mcnt < W) mcnt++;
`endif
          end
        endcase
      end
      chk_all("rnd", n, mq, mso, mcnt);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/d_register_universal.md
# d_register_universal

Parametrised successor to the team's 1-bit D flip-flop with set/reset. It is a WIDTH-bit register with synchronous reset and set, a load-enable, and four operating modes: parallel load, shift left, shift right and rotate. A saturating shift counter and done flag let a parent block use it as a parallel-to-serial converter without any external counting. It sits in the datapath wherever a flop bank, serializer or shift stage is needed.

## Interface
- WIDTH, 8, register width in bits; must be at least 2.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q on reset.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; highest priority.
- set  input  1  synchronous, active-high; drives Q to all ones; priority below reset.
- en  input  1  operation enable; when low, Q holds its value.
- mode  input  2  operation select: 00 load, 01 shift left, 10 shift right, 11 rotate left.
- data  input  WIDTH  parallel load value.
- serial_in  input  1  bit shifted into the vacated end during shift modes.
- Q  output  WIDTH  register contents.
- Q_bar  output  WIDTH  bitwise complement of Q.
- serial_out  output  1  bit most recently shifted or rotated out; registered.
- shift_count  output  $clog2(WIDTH+1)  number of shift or rotate operations since the last load, set or reset; saturates at WIDTH.
- shift_done  output  1  high while shift_count == WIDTH.

## Operation
- Only one clock and one reset in the block; no asynchronous paths.
- Priority on each rising edge: reset > set > en. With en low, everything holds.
- reset: Q = RESET_VALUE, serial_out = 0, shift_count = 0.
- set: Q = all ones, serial_out = 0, shift_count = 0.
- mode 00 (load): Q = data, shift_count = 0, serial_out holds.
- mode 01 (shift left): serial_out = Q[WIDTH-1], Q = {Q[WIDTH-2:0], serial_in}.
- mode 10 (shift right): serial_out = Q[0], Q = {serial_in, Q[WIDTH-1:1]}.
- mode 11 (rotate left, ROTATE_EN defined): serial_out = Q[WIDTH-1], Q = {Q[WIDTH-2:0], Q[WIDTH-1]}; serial_in is ignored.
- shift_count behaviour:
  - increments by 1 on every enabled shift or rotate while below WIDTH.
  - at WIDTH it saturates. Further shifts still move Q.
- Q_bar = ~Q, combinational from the Q register, so it never diverges from Q.
- shift_done = (shift_count == WIDTH), combinational from the counter.

## Timing
- Every registered update takes effect one cycle after the controlling edge.
- Load to first shifted bit on serial_out: 1 cycle.
- A WIDTH-bit word is fully serialized after WIDTH consecutive enabled shifts. shift_done rises in the same cycle that the last bit appears on serial_out.
- Simultaneous reset and set: the reset result wins.
- set with en high: the set result wins and mode is ignored.
- Reset mid-shift: the counter clears immediately and the next edge starts from RESET_VALUE.
- Mode changes take effect on the next edge. Mixing left and right shifts keeps counting.

## Configuration
- Macro: D_REGISTER_UNIVERSAL_ROTATE_EN.
- Defined: mode 11 performs rotate left as described in Operation, and the rotate counts toward shift_count.
- Undefined: mode 11 behaves as a hold. Q, serial_out and shift_count are all unchanged, even with en high.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert reset for 1 cycle with set=1 and en=1 -> Q=8'h00, Q_bar=8'hFF, serial_out=0, shift_count=0, shift_done=0.
- Load then hold: load data=8'hA5 with mode 00 -> Q=8'hA5 next cycle. Drop en for 3 cycles -> Q stays 8'hA5.
- Serialize: load 8'hA5, then 8 shift-left edges with serial_in=0 -> serial_out sequence 1,0,1,0,0,1,0,1. Q=8'h00, shift_count=8, shift_done=1. A 9th shift leaves shift_count at 8.
- Shift right fill: start from Q=8'h00, then 4 shift-right edges with serial_in=1 -> Q=8'hF0, serial_out=0, shift_count=4.
- Set priority and rotate:
  - set=1 with mode 01 -> Q=8'hFF, shift_count=0.
  - Then load 8'h81 and rotate once -> with the macro defined, Q=8'h03 and serial_out=1; without it, Q stays 8'h81.
- Reset mid-operation: reset during the 4th of 8 shifts -> next cycle Q=RESET_VALUE and shift_count=0.
